button_conditioner: RTL
=======================

# button_conditioner

Input front end that produces the `button_up` and `button_down` levels consumed by the player controller. Raw asynchronous push-button pins are synchronised and debounced. The up-button press is held as a one-shot request until the next `game_tick[0]` so that no press between ticks is lost. The block sits between the board pins and the player controller and is the only source of those two signals.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4 — consecutive stable synchronised samples required before a debounced level changes. Legal range is 1..65535.

Ports:
- `clk` input 1 — system clock.
- `rst_n` input 1 — reset, asynchronous assert, active-low.
- `game_tick` input 2 — frame tick bus. Bit 0 is the consume strobe; bit 1 is ignored.
- `btn_up_raw` input 1 — raw up-button pin, asynchronous, active-high.
- `btn_down_raw` input 1 — raw down-button pin, asynchronous, active-high.
- `button_up` output 1 — latched up-press request, registered.
- `button_down` output 1 — debounced down level, registered.
- `up_held` output 1 — debounced up level, registered, for diagnostics.

## Operation
- **Synchroniser:** a 2-flop synchroniser per pin. All flops reset to 0.
- **Debouncer, per button:**
  - Holds a stable level `db` (reset 0) and a counter of width clog2(DEBOUNCE_CYCLES+1) (reset 0).
  - If the synchronised value equals `db`, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while the value still differs, `db` toggles and the counter clears on the same edge.
  - Any agreeing sample restarts the count.
  - The counter saturates and never wraps.
- **Rise detect:** `db_up_q` is the registered copy of `db_up` (reset 0). `up_rise = db_up & ~db_up_q`.
- **Up request latch `up_req` (reset 0), evaluated each edge in priority order:**
  1. If `up_rise` is high, set to 1. A set wins over a clear, including when it coincides with `game_tick[0]`.
  2. Else if `game_tick[0]` is high, clear to 0.
  3. Otherwise hold.
- **Outputs:** `button_up = up_req`, `button_down = db_down`, `up_held = db_up`.
- **Holding and repeats:**
  - Holding up produces exactly one request. No auto-repeat.
  - A new request requires release (debounced low) and then a re-press.
- **Up and down are independent.** Both may be asserted together; priority is resolved downstream.
- **Reset mid-operation:** all state clears asynchronously. A button held through reset release is seen as a fresh press once debounced.

## Timing
- Reset value of every output is 0.
- Synchronised sample lags the pin by 2 clocks.
- `button_down` and `up_held` change 2 + DEBOUNCE_CYCLES clocks after a clean pin edge.
- `button_up` rises 1 clock after `up_held` rises.
- With a clean edge and no tick in between, total pin-to-`button_up` latency is 3 + DEBOUNCE_CYCLES clocks.
- `button_up` is high during the cycle in which `game_tick[0]` is sampled high, so the consumer sees `game_tick[0] && button_up` in that cycle. It is low from the next cycle, unless re-set by a coincident rise.
- If `game_tick[0]` is high in the same cycle `up_req` first sets, the request survives to the next tick.
- Glitches shorter than DEBOUNCE_CYCLES synchronised cycles produce no output change.

## Configuration
- `BUTTON_DEBOUNCE_EN` defined: the debouncers operate as above.
- `BUTTON_DEBOUNCE_EN` undefined: counters are not instantiated and `db` is the registered synchronised value.
  - Latency becomes 3 clocks to `up_held`/`button_down` and 4 clocks to `button_up`.
  - `DEBOUNCE_CYCLES` is ignored.
  - All other behaviour is unchanged.

## Structure
- Shared package `dino_pkg`:
  - `DEBOUNCE_CYCLES_DEFAULT` = 4.
  - Tick bit index constant `TICK_FRAME` = 0.
- Sub-module `button_debounce`: synchroniser, counter and stable level for one pin, parameterised by `DEBOUNCE_CYCLES`, also gated by `BUTTON_DEBOUNCE_EN`. It is instantiated twice.
- The top level holds the rise detect and the `up_req` latch.

## Test plan
- **Reset:** assert `rst_n`=0 mid-count with `btn_up_raw`=1 → all outputs 0 immediately. After release, `up_held` rises 6 clocks later and `button_up` 7 clocks later (DEBOUNCE_CYCLES=4).
- **Glitch:** `btn_down_raw` high for 3 clocks, then low → `button_down` stays 0. Held for 10 clocks → `button_down` rises at clock 6 and falls 6 clocks after release.
- **Consume:** press up, then `game_tick[0]` pulses 20 clocks later → `button_up` high from clock 7 through the tick cycle, low the cycle after. Held for 200 clocks with ticks every 16 → exactly one tick sees `button_up`=1.
- **Coincident set/clear:** `game_tick[0]` high in the same cycle `up_rise` is high → `button_up` remains 1 and clears only at the following tick.
- **Re-press:** release up, then re-press with no intervening tick → a single pending request (`button_up`=1) that clears at the next tick. Both buttons pressed together → `button_up`=1 and `button_down`=1 concurrently.
- **Macro off:** compile without `BUTTON_DEBOUNCE_EN` → a 1-clock pulse on `btn_up_raw` yields `up_held` high for 1 clock and `button_up` set 4 clocks after the pin edge.

Source files
------------

// File: rtl/dino_pkg.sv
// Shared constants for the dino game front end: debounce default and tick bus layout.
package dino_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 4;
  localparam int unsigned TICK_W                  = 2;
  localparam int unsigned TICK_FRAME              = 0;

endpackage

// File: rtl/button_debounce.sv
// One push-button pin: 2-flop synchroniser followed by a stable-level debouncer.
// BUTTON_DEBOUNCE_EN selects the counting debouncer; otherwise o_db is the registered synchronised pin.
module button_debounce
  import dino_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_db
);

  logic [1:0] r_sync;
  logic       w_sync;
  logic       r_db;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= 2'b00;
    else        r_sync <= {r_sync[0], i_raw};
  end

  assign w_sync = r_sync[1];

`ifdef BUTTON_DEBOUNCE_EN
  localparam int unsigned          CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]     CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] r_cnt;

  // Count consecutive disagreeing samples; the Nth one flips the stable level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db  <= 1'b0;
      r_cnt <= '0;
    end else if (w_sync == r_db) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_db  <= ~r_db;
      r_cnt <= '0;
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_db <= 1'b0;
    else        r_db <= w_sync;
  end
`endif

  assign o_db = r_db;

endmodule

// File: rtl/button_conditioner.sv
// Up/down button front end: debounced levels plus a one-shot up request held until game_tick[0].
// Debouncing counters are present only when BUTTON_DEBOUNCE_EN is defined.
module button_conditioner
  import dino_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TICK_W-1:0] game_tick,
  input  logic              btn_up_raw,
  input  logic              btn_down_raw,
  output logic              button_up,
  output logic              button_down,
  output logic              up_held
);

  logic w_db_up;
  logic w_db_down;
  logic w_up_rise;
  logic w_tick;
  logic w_unused_tick;
  logic r_db_up_q;
  logic r_up_req;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk   (clk),
    .rst_n (rst_n),
    .i_raw (btn_up_raw),
    .o_db  (w_db_up)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk   (clk),
    .rst_n (rst_n),
    .i_raw (btn_down_raw),
    .o_db  (w_db_down)
  );

  assign w_tick        = game_tick[TICK_FRAME];
  assign w_unused_tick = game_tick[1];
  assign w_up_rise     = w_db_up & ~r_db_up_q;

  // A fresh press sets the request even when it lands on a consuming tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db_up_q <= 1'b0;
      r_up_req  <= 1'b0;
    end else begin
      r_db_up_q <= w_db_up;
      if (w_up_rise)   r_up_req <= 1'b1;
      else if (w_tick) r_up_req <= 1'b0;
    end
  end

  assign button_up   = r_up_req;
  assign button_down = w_db_down;
  assign up_held     = w_db_up;

endmodule
